pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Sources it arbitrates: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses.
- Drives every pipeline-register `en` and per-stage bubble/flush controls.
- Contains a wait-state FSM with timeout and sticky error.

---
 rtl/pipe_ctrl_pkg.sv | 47 ++++
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Includes the FSM state encoding and the per-cycle enable/flush bundle.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  typedef struct packed {
    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '0;

  // Priority of the non-memory sources once memory is not holding the pipe:
  // a taken branch squashes everything younger, otherwise a load-use hazard
  // holds PC and IF/ID while a bubble goes into ID/EX.
  function automatic ctrl_t run_ctrl(input logic branch, input logic hz);
    ctrl_t c;
    c = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1,
          en_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0,
          flush_ex_mem: 1'b0};
    if (branch) begin
      c.flush_if_id  = 1'b1;
      c.flush_id_ex  = 1'b1;
      c.flush_ex_mem = 1'b1;
    end else if (hz) begin
      c.en_pc       = 1'b0;
      c.en_if_id    = 1'b0;
      c.flush_id_ex = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave): hazard sources in, register enables/flushes and status out.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_memread;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_branch_taken;
  logic                  dmem_req;
  logic                  dmem_ready;

  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           mem_branch_taken, dmem_req, dmem_ready,
    input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           mem_branch_taken, dmem_req, dmem_ready,
    output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the ID instruction reads a register
// that the load currently in EX has not yet produced (x0 never hazards).
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  output logic                  o_hz
);
  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_match = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hz = i_ex_memread && (i_ex_rd != REG_X0) && (w_rs1_match || w_rs2_match);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for PC and the four pipeline registers, with a memory
// wait-state FSM (timeout -> sticky err). Perf counters need PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               arst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_nxt, w_wait_inc;
  logic             r_err, w_err_nxt;
  logic             w_hz;
  logic             w_mem_busy;
  ctrl_t            w_ctrl_raw, w_ctrl;

  load_use_detect u_load_use_detect (
    .i_ex_memread (bus.ex_memread),
    .i_ex_rd      (bus.ex_rd),
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .i_id_use_rs1 (bus.id_use_rs1),
    .i_id_use_rs2 (bus.id_use_rs2),
    .o_hz         (w_hz)
  );

  assign w_mem_busy = bus.dmem_req && !bus.dmem_ready;
  assign w_wait_inc = r_wait_cnt + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_err;
    w_ctrl_raw  = CTRL_FREEZE;
    case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = CNT_W'(1);
        end else begin
          w_ctrl_raw = run_ctrl(bus.mem_branch_taken, w_hz);
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc >= TIMEOUT_C) begin
            w_state_nxt = HALT;
            w_err_nxt   = 1'b1;
          end
        end else begin
          // Upstream was frozen, so any branch/hazard seen now is the one held
          // through the wait and is serviced on this ready cycle.
          w_ctrl_raw  = run_ctrl(bus.mem_branch_taken, w_hz);
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end
      end
      HALT: begin
        w_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Reset freezes the whole pipe immediately, not at the next edge.
  assign w_ctrl = arst_n ? w_ctrl_raw : CTRL_FREEZE;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.en_pc        = w_ctrl.en_pc;
  assign bus.en_if_id     = w_ctrl.en_if_id;
  assign bus.en_id_ex     = w_ctrl.en_id_ex;
  assign bus.en_ex_mem    = w_ctrl.en_ex_mem;
  assign bus.en_mem_wb    = w_ctrl.en_mem_wb;
  assign bus.flush_if_id  = w_ctrl.flush_if_id;
  assign bus.flush_id_ex  = w_ctrl.flush_id_ex;
  assign bus.flush_ex_mem = w_ctrl.flush_ex_mem;
  assign bus.err          = r_err;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // flush_ex_mem is raised only by a taken branch, so it marks flush events.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.en_pc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_ctrl.flush_ex_mem && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, all compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic arst_n;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: waiting cycles so far (0 = not waiting), halted, err, counters.
  int m_wait  = 0;
  bit m_halt  = 0;
  bit m_err   = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] obs_ctrl();
    return {bus.en_pc, bus.en_if_id, bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb,
            bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
  endfunction

  function automatic bit model_hz();
    return bus.ex_memread && (bus.ex_rd != 0) &&
           ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
  endfunction

  // Memory holds the pipe when it is not ready and either a new access starts
  // or we are already waiting.
  function automatic bit model_mem_stall();
    return !bus.dmem_ready && (bus.dmem_req || m_wait > 0);
  endfunction

  function automatic logic [7:0] model_ctrl();
    if (!arst_n || m_halt || model_mem_stall()) return 8'b00000_000;
    if (bus.mem_branch_taken)                   return 8'b11111_111;
    if (model_hz())                             return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit memread, input int rd, input bit br,
                        input bit req, input bit rdy);
    bus.id_rs1           = 5'(rs1);
    bus.id_rs2           = 5'(rs2);
    bus.id_use_rs1       = u1;
    bus.id_use_rs2       = u2;
    bus.ex_memread       = memread;
    bus.ex_rd            = 5'(rd);
    bus.mem_branch_taken = br;
    bus.dmem_req         = req;
    bus.dmem_ready       = rdy;
  endtask

  task automatic set_idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge: check combinational outputs for the
  // current inputs, clock once, advance the model, then check registered state.
  task automatic tick(input string tag);
    logic [7:0] exp_ctrl;
    #2;
    exp_ctrl = model_ctrl();
    check({tag, "/ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl));
    @(posedge clk);
    if (!m_halt) begin
      if (model_mem_stall()) begin
        m_wait = (m_wait > 0) ? m_wait + 1 : 1;
        if (m_wait >= MEM_TIMEOUT) begin
          m_halt = 1;
          m_err  = 1;
        end
      end else begin
        m_wait = 0;
      end
    end
    if (!exp_ctrl[7] && m_stall < CNT_MAX) m_stall++;
    if (exp_ctrl[0] && m_flush < CNT_MAX) m_flush++;
    #1;
    check({tag, "/err"},   32'(bus.err),       32'(m_err));
    check({tag, "/stall"}, 32'(bus.stall_cnt), PERF ? 32'(m_stall) : 32'd0);
    check({tag, "/flush"}, 32'(bus.flush_cnt), PERF ? 32'(m_flush) : 32'd0);
  endtask

  // Asynchronous reset pulse landing mid-cycle; outputs must drop at once.
  task automatic do_reset(input string tag);
    set_idle();
    @(negedge clk);
    #1 arst_n = 1'b0;
    m_wait = 0; m_halt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    #1;
    check({tag, "/rst_ctrl"},  32'(obs_ctrl()),   32'(model_ctrl()));
    check({tag, "/rst_err"},   32'(bus.err),       32'd0);
    check({tag, "/rst_stall"}, 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    set_idle();
    do_reset("por");
    set_idle(); tick("idle");

    // Load-use on rs1, then the hazard clears.
    set_in(5, 0, 1, 0, 1, 5, 0, 0, 0); tick("lu_rs1");
    set_idle();                        tick("lu_after");
    // Same stimulus with the load targeting x0: no stall.
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 0); tick("lu_x0");
    // Load-use on rs2; rs2 match with use_rs2 low does not stall.
    set_in(1, 7, 0, 1, 1, 7, 0, 0, 0); tick("lu_rs2");
    set_in(1, 7, 0, 0, 1, 7, 0, 0, 0); tick("lu_nouse");
    set_in(5, 0, 1, 0, 0, 5, 0, 0, 0); tick("lu_noload");

    // Branch coincident with the load-use pattern: branch wins.
    set_in(5, 0, 1, 0, 1, 5, 1, 0, 0); tick("br_lu");
    set_idle();                        tick("br_after");

    // Zero-wait memory access.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); tick("dmem_0wait");

    // Three stall cycles, then ready.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick($sformatf("mw3_%0d", i));
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); tick("mw3_ready");
    set_idle();                        tick("mw3_after");

    // Branch held through a wait is serviced on the ready cycle.
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); tick($sformatf("mwbr_%0d", i));
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1); tick("mwbr_ready");
    // Hazard held through a wait.
    set_in(3, 0, 1, 0, 1, 3, 0, 1, 0); tick("mwhz_wait");
    set_in(3, 0, 1, 0, 1, 3, 0, 1, 1); tick("mwhz_ready");
    set_idle();                        tick("mwhz_after");

    // Timeout: err after the 4th wait cycle, frozen until reset; stall_cnt saturates.
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick($sformatf("to_%0d", i));
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1); tick("halt_ready");
    for (int i = 0; i < 16; i++) begin
      set_idle(); tick($sformatf("halt_%0d", i));
    end
    do_reset("to_rst");
    set_idle(); tick("to_recover");

    // Reset asserted mid-wait returns to RUN.
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick($sformatf("mwrst_%0d", i));
    end
    do_reset("mwrst");
    set_idle(); tick("mwrst_run");

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset("rnd_rst");
      set_in($urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      tick($sformatf("rnd_%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
